// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker and the parity generator side.
package serial_parity_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_BITS data bits plus a parity bit, checks parity and counts bad frames.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 3,
  parameter bit          ODD_PARITY = PAR_EVEN,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clr_cnt,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_done,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 acc_q, acc_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    // start overrides bit_valid in every state, including an in-progress frame
    if (start) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      shift_d = '0;
      acc_d   = ODD_PARITY;
    end else begin
      unique case (state_q)
        ST_DATA: begin
          if (bit_valid) begin
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (cnt_q == CNT_W'(i)) shift_d[i] = bit_in;
            end
            acc_d = acc_q ^ bit_in;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            data_d  = shift_q;
            perr_d  = acc_q ^ bit_in;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      acc_q   <= ODD_PARITY;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Counts during the frame_done cycle, so a clr_cnt in that cycle wins
  sat_counter #(
    .WIDTH(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (done_q & perr_q),
    .clr  (clr_cnt),
    .count(err_count)
  );

  assign busy       = busy_q;
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed and randomized checks of three serial_parity_checker configurations.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_i [3];
  logic        bit_i   [3];
  logic        valid_i [3];
  logic        clr_i   [3];
  logic        busy_o  [3];
  logic        perr_o  [3];
  logic        fd_o    [3];
  logic [31:0] data_o  [3];
  logic [31:0] err_o   [3];

  logic [2:0] d0_data;
  logic [7:0] d1_data;
  logic [2:0] d2_data;
  logic [7:0] d0_err;
  logic [7:0] d1_err;
  logic [1:0] d2_err;

  serial_parity_checker #(.DATA_BITS(3), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_even3 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .bit_in(bit_i[0]), .bit_valid(valid_i[0]),
    .clr_cnt(clr_i[0]), .busy(busy_o[0]), .data_out(d0_data), .parity_err(perr_o[0]),
    .frame_done(fd_o[0]), .err_count(d0_err));

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .bit_in(bit_i[1]), .bit_valid(valid_i[1]),
    .clr_cnt(clr_i[1]), .busy(busy_o[1]), .data_out(d1_data), .parity_err(perr_o[1]),
    .frame_done(fd_o[1]), .err_count(d1_err));

  serial_parity_checker #(.DATA_BITS(3), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .bit_in(bit_i[2]), .bit_valid(valid_i[2]),
    .clr_cnt(clr_i[2]), .busy(busy_o[2]), .data_out(d2_data), .parity_err(perr_o[2]),
    .frame_done(fd_o[2]), .err_count(d2_err));

  assign data_o[0] = 32'(d0_data);
  assign data_o[1] = 32'(d1_data);
  assign data_o[2] = 32'(d2_data);
  assign err_o[0]  = 32'(d0_err);
  assign err_o[1]  = 32'(d1_err);
  assign err_o[2]  = 32'(d2_err);

  // Reference model state
  int nb     [3] = '{3, 8, 3};
  int oddp   [3] = '{0, 1, 0};
  int errmax [3] = '{255, 255, 3};
  int exp_err  [3];
  int exp_data [3];
  int exp_perr [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_perr(input int d, input logic [31:0] w, input logic p);
    int ones = int'(p);
    for (int i = 0; i < nb[d]; i++) ones += int'(w[i]);
    return ((ones % 2) != oddp[d]) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start_i[d] = 1'b1;
    tick();
    start_i[d] = 1'b0;
    chk("busy_after_start", 32'(busy_o[d]), 32'd1);
  endtask

  // Sends data and parity bits of a frame already started, then checks the result.
  task automatic send_body(input int d, input logic [31:0] word, input logic par,
                           input int gap, input bit clr);
    for (int i = 0; i <= nb[d]; i++) begin
      repeat (gap) tick();
      bit_i[d]   = (i < nb[d]) ? word[i] : par;
      valid_i[d] = 1'b1;
      tick();
      valid_i[d] = 1'b0;
      if (i < nb[d]) chk("no_done_mid_frame", 32'(fd_o[d]), 32'd0);
    end
    exp_data[d] = int'(word & 32'((64'd1 << nb[d]) - 64'd1));
    exp_perr[d] = ref_perr(d, word, par);
    chk("frame_done", 32'(fd_o[d]), 32'd1);
    chk("data_out", data_o[d], 32'(exp_data[d]));
    chk("parity_err", 32'(perr_o[d]), 32'(exp_perr[d]));
    chk("err_before_update", err_o[d], 32'(exp_err[d]));
    clr_i[d] = clr;
    if (clr) exp_err[d] = 0;
    else if (exp_perr[d] == 1 && exp_err[d] < errmax[d]) exp_err[d]++;
    tick();
    clr_i[d] = 1'b0;
    chk("done_one_cycle", 32'(fd_o[d]), 32'd0);
    chk("busy_idle", 32'(busy_o[d]), 32'd0);
    chk("err_count", err_o[d], 32'(exp_err[d]));
    chk("data_held", data_o[d], 32'(exp_data[d]));
  endtask

  task automatic send(input int d, input logic [31:0] word, input logic par,
                      input int gap, input bit clr);
    pulse_start(d);
    send_body(d, word, par, gap, clr);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_i[d] = 1'b0; bit_i[d] = 1'b0; valid_i[d] = 1'b0; clr_i[d] = 1'b0;
      exp_err[d] = 0; exp_data[d] = 0; exp_perr[d] = 0;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", 32'(busy_o[d]), 32'd0);
      chk("rst_data", data_o[d], 32'd0);
      chk("rst_perr", 32'(perr_o[d]), 32'd0);
      chk("rst_done", 32'(fd_o[d]), 32'd0);
      chk("rst_err", err_o[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // bit_valid in IDLE without start does nothing
    bit_i[0] = 1'b1; valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    chk("idle_valid_busy", 32'(busy_o[0]), 32'd0);
    chk("idle_valid_done", 32'(fd_o[0]), 32'd0);

    // Clean even frame, bad frame, back-to-back bad repeat
    send(0, 32'b101, 1'b0, 0, 1'b0);
    send(0, 32'b011, 1'b1, 0, 1'b0);
    send(0, 32'b011, 1'b1, 0, 1'b0);
    chk("err_two", err_o[0], 32'd2);

    // Odd mode, 8 bits
    send(1, 32'hA5, 1'b1, 0, 1'b0);
    chk("odd_good", 32'(perr_o[1]), 32'd0);
    send(1, 32'hA5, 1'b0, 0, 1'b0);
    chk("odd_bad", 32'(perr_o[1]), 32'd1);

    // Abort after two bits with start+bit_valid together; the colliding bit is ignored
    pulse_start(0);
    for (int i = 0; i < 2; i++) begin
      bit_i[0] = 1'b1; valid_i[0] = 1'b1;
      tick();
      valid_i[0] = 1'b0;
    end
    start_i[0] = 1'b1; bit_i[0] = 1'b1; valid_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0; valid_i[0] = 1'b0;
    chk("abort_no_done", 32'(fd_o[0]), 32'd0);
    chk("abort_busy", 32'(busy_o[0]), 32'd1);
    send_body(0, 32'b110, 1'b0, 0, 1'b0);
    chk("abort_err_kept", err_o[0], 32'd2);

    // Gaps between bits
    send(0, 32'b101, 1'b0, 3, 1'b0);

    // Asynchronous reset mid-DATA
    pulse_start(0);
    bit_i[0] = 1'b1; valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o[0]), 32'd0);
    chk("midrst_data", data_o[0], 32'd0);
    chk("midrst_err", err_o[0], 32'd0);
    chk("midrst_data_odd8", data_o[1], 32'd0);
    for (int d = 0; d < 3; d++) begin
      exp_err[d] = 0; exp_data[d] = 0; exp_perr[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 32'b110, 1'b1, 0, 1'b0);

    // Randomized frames on both 3-bit even and 8-bit odd instances
    for (int n = 0; n < 24; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      send(d, 32'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Saturation on the 2-bit counter, then clear colliding with an increment
    for (int n = 0; n < 5; n++) send(2, 32'b011, 1'b1, 0, 1'b0);
    chk("sat_hold", err_o[2], 32'd3);
    send(2, 32'b001, 1'b0, 0, 1'b1);
    chk("clr_wins", err_o[2], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
